// File: rtl/cordic_vectoring.sv
// Pipelined 16-iteration CORDIC vectoring core: (X,Y) -> angle, quadrant phase, magnitude, residual.
// Optional macro CORDIC_GAIN_COMP_EN adds a gain-compensation multiply stage (latency 19 instead of 18).
module cordic_vectoring #(
    parameter int unsigned DATA_W = 32,
    parameter logic [31:0] K      = 32'h09B74
) (
    input  logic              CLK_50M,
    input  logic              RST_N,
    input  logic              In_Valid,
    input  logic [DATA_W-1:0] X_In,
    input  logic [DATA_W-1:0] Y_In,
    output logic              Out_Valid,
    output logic [31:0]       Angle,
    output logic [31:0]       Phase_Out,
    output logic [DATA_W-1:0] Magnitude,
    output logic [DATA_W-1:0] Residual
);
    localparam int unsigned W  = DATA_W + 2;
    localparam int unsigned NI = 16;
    localparam logic signed [33:0] Deg90  = 34'sd5898240;
    localparam logic signed [33:0] Deg360 = 34'sd23592960;

    // atan(2^-i) in degrees, Q16
    function automatic logic [31:0] rot_const(input int i);
        case (i)
            0:       return 32'd2949120;
            1:       return 32'd1740992;
            2:       return 32'd919872;
            3:       return 32'd466944;
            4:       return 32'd234368;
            5:       return 32'd117312;
            6:       return 32'd58688;
            7:       return 32'd29312;
            8:       return 32'd14656;
            9:       return 32'd7360;
            10:      return 32'd3648;
            11:      return 32'd1856;
            12:      return 32'd896;
            13:      return 32'd448;
            14:      return 32'd256;
            15:      return 32'd128;
            default: return 32'd0;
        endcase
    endfunction

    logic signed [W-1:0] x_q [NI+1];
    logic signed [W-1:0] y_q [NI+1];
    logic signed [W-1:0] z_q [NI+1];
    logic [1:0]          q_q [NI+1];
    logic [NI:0]         v_q;
    logic [NI:0]         zero_q;

    logic signed [W-1:0] x_n [NI];
    logic signed [W-1:0] y_n [NI];
    logic signed [W-1:0] z_n [NI];

    logic signed [W-1:0] xi, yi, x_f, y_f;
    logic [1:0]          q_f;

    assign xi = W'($signed(X_In));
    assign yi = W'($signed(Y_In));

    // Fold the input into the first quadrant, remembering which quadrant it came from
    always_comb begin
        x_f = xi;
        y_f = yi;
        q_f = 2'd0;
        case ({X_In[DATA_W-1], Y_In[DATA_W-1]})
            2'b00: begin x_f = xi;  y_f = yi;  q_f = 2'd0; end
            2'b10: begin x_f = yi;  y_f = -xi; q_f = 2'd1; end
            2'b11: begin x_f = -xi; y_f = -yi; q_f = 2'd2; end
            2'b01: begin x_f = -yi; y_f = xi;  q_f = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < int'(NI); i++) begin
            if (!y_q[i][W-1]) begin
                x_n[i] = x_q[i] + (y_q[i] >>> i);
                y_n[i] = y_q[i] - (x_q[i] >>> i);
                z_n[i] = z_q[i] + W'(rot_const(i));
            end else begin
                x_n[i] = x_q[i] - (y_q[i] >>> i);
                y_n[i] = y_q[i] + (x_q[i] >>> i);
                z_n[i] = z_q[i] - W'(rot_const(i));
            end
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i <= int'(NI); i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
                q_q[i] <= '0;
            end
            v_q    <= '0;
            zero_q <= '0;
        end else begin
            x_q[0]    <= x_f;
            y_q[0]    <= y_f;
            z_q[0]    <= '0;
            q_q[0]    <= q_f;
            v_q[0]    <= In_Valid;
            zero_q[0] <= (X_In == '0) && (Y_In == '0);
            for (int i = 0; i < int'(NI); i++) begin
                x_q[i+1] <= x_n[i];
                y_q[i+1] <= y_n[i];
                z_q[i+1] <= z_n[i];
                q_q[i+1] <= q_q[i];
            end
            v_q[NI:1]    <= v_q[NI-1:0];
            zero_q[NI:1] <= zero_q[NI-1:0];
        end
    end

    logic signed [W-1:0] x_t, y_t, z_t;
    logic [1:0]          q_t;
    logic                v_t, zero_t;

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [W+32:0] prod;
    logic signed [W-1:0]  xc_q, yc_q, zc_q;
    logic [1:0]           qc_q;
    logic                 vc_q, zeroc_q;

    assign prod = x_q[NI] * $signed({1'b0, K});

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            xc_q    <= '0;
            yc_q    <= '0;
            zc_q    <= '0;
            qc_q    <= '0;
            vc_q    <= 1'b0;
            zeroc_q <= 1'b0;
        end else begin
            xc_q    <= W'(prod >>> 16);
            yc_q    <= y_q[NI];
            zc_q    <= z_q[NI];
            qc_q    <= q_q[NI];
            vc_q    <= v_q[NI];
            zeroc_q <= zero_q[NI];
        end
    end

    assign x_t    = xc_q;
    assign y_t    = yc_q;
    assign z_t    = zc_q;
    assign q_t    = qc_q;
    assign v_t    = vc_q;
    assign zero_t = zeroc_q;
`else
    assign x_t    = x_q[NI];
    assign y_t    = y_q[NI];
    assign z_t    = z_q[NI];
    assign q_t    = q_q[NI];
    assign v_t    = v_q[NI];
    assign zero_t = zero_q[NI];
`endif

    logic signed [33:0] z_ext, ang, deg;
    logic [31:0]        angle_d, phase_d;

    always_comb begin
        z_ext = 34'(z_t);
        ang   = z_ext + Deg90 * $signed({32'b0, q_t});
        if (ang < 34'sd0) begin
            ang = ang + Deg360;
        end else if (ang >= Deg360) begin
            ang = ang - Deg360;
        end
        deg = (z_ext + 34'sd32768) >>> 16;
        if (deg < 34'sd0) begin
            deg = '0;
        end else if (deg > 34'sd90) begin
            deg = 34'sd90;
        end
        angle_d = ang[31:0];
        phase_d = {14'b0, q_t, deg[15:0]};
        // An all-zero input never drives y negative, so z would otherwise sum every rotation
        if (zero_t) begin
            angle_d = '0;
            phase_d = '0;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            Out_Valid <= 1'b0;
            Angle     <= '0;
            Phase_Out <= '0;
            Magnitude <= '0;
            Residual  <= '0;
        end else begin
            Out_Valid <= v_t;
            if (v_t) begin
                Angle     <= angle_d;
                Phase_Out <= phase_d;
                Magnitude <= x_t[DATA_W-1:0];
                Residual  <= y_t[DATA_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed self-checking bench for cordic_vectoring (default DATA_W = 32).
module tb_cordic_vectoring;
    localparam int ATOL = 655;
    localparam longint FULL = 64'd23592960;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT   = 19;
    localparam int MAG1  = 'h10000;
    localparam int TOL1  = 'h40;
    localparam int MAG45 = 'h16A0A;
    localparam int TOL45 = 'h60;
`else
    localparam int LAT   = 18;
    localparam int MAG1  = 'h1A592;
    localparam int TOL1  = 'h70;
    localparam int MAG45 = 'h2543F;
    localparam int TOL45 = 'h90;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] x_in = '0;
    logic [31:0] y_in = '0;
    logic        out_valid;
    logic [31:0] angle, phase_out, magnitude, residual;

    int n_checks = 0;
    int n_fail = 0;

    cordic_vectoring dut (
        .CLK_50M   (clk),
        .RST_N     (rst_n),
        .In_Valid  (in_valid),
        .X_In      (x_in),
        .Y_In      (y_in),
        .Out_Valid (out_valid),
        .Angle     (angle),
        .Phase_Out (phase_out),
        .Magnitude (magnitude),
        .Residual  (residual)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Circular distance between an observed angle and the ideal one, in Q16 degrees
    function automatic int angerr(input logic [31:0] a, input longint e);
        longint d;
        d = longint'(a) - e;
        if (d < 0) d = -d;
        if (d > FULL / 2) d = FULL - d;
        return int'(d);
    endfunction

    function automatic int absdiff(input logic [31:0] a, input int e);
        int d;
        d = int'(a) - e;
        return (d < 0) ? -d : d;
    endfunction

    // Sends one sample into an idle pipe and captures the result; lat = -1 on timeout
    task automatic run_one(input logic [31:0] x, input logic [31:0] y, output int lat,
                           output logic [31:0] ang, output logic [31:0] ph,
                           output logic [31:0] mag, output logic [31:0] res);
        @(negedge clk);
        in_valid = 1'b1;
        x_in = x;
        y_in = y;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        ang = angle;
        ph  = phase_out;
        mag = magnitude;
        res = residual;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (angle !== 32'h0) begin n_fail++; $display("FAIL reset_angle got %h want 0", angle); end
        if (phase_out !== 32'h0) begin n_fail++; $display("FAIL reset_phase got %h want 0", phase_out); end
        if (magnitude !== 32'h0) begin n_fail++; $display("FAIL reset_mag got %h want 0", magnitude); end
        if (residual !== 32'h0) begin n_fail++; $display("FAIL reset_res got %h want 0", residual); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unit_vectors;
        int lat;
        logic [31:0] a, p, m, r;
        // (1,0): angle 0, phase 0
        run_one(32'h10000, 32'h0, lat, a, p, m, r);
        n_checks += 5;
        if (lat != LAT) begin n_fail++; $display("FAIL latency got %0d want %0d", lat, LAT); end
        if (angerr(a, 0) > ATOL) begin n_fail++; $display("FAIL ang_0 got %h want 0", a); end
        if (p !== 32'h0) begin n_fail++; $display("FAIL phase_0 got %h want 0", p); end
        if (absdiff(m, MAG1) > TOL1) begin n_fail++; $display("FAIL mag_0 got %h want %h", m, MAG1); end
        if (absdiff(r, 0) > 64) begin n_fail++; $display("FAIL res_0 got %h want ~0", r); end
        // (1,1): 45 degrees
        run_one(32'h10000, 32'h10000, lat, a, p, m, r);
        n_checks += 4;
        if (angerr(a, 64'h2D0000) > ATOL) begin n_fail++; $display("FAIL ang_45 got %h want 2d0000", a); end
        if (p !== 32'h2D) begin n_fail++; $display("FAIL phase_45 got %h want 2d", p); end
        if (absdiff(m, MAG45) > TOL45) begin n_fail++; $display("FAIL mag_45 got %h want %h", m, MAG45); end
        if (absdiff(r, 0) > 64) begin n_fail++; $display("FAIL res_45 got %h want ~0", r); end
        // (-1,0): quadrant 1, 90 within quadrant, angle 180
        run_one(-32'sh10000, 32'h0, lat, a, p, m, r);
        n_checks += 3;
        if (angerr(a, 64'hB40000) > ATOL) begin n_fail++; $display("FAIL ang_180 got %h want b40000", a); end
        if (p !== 32'h1005A) begin n_fail++; $display("FAIL phase_180 got %h want 1005a", p); end
        if (absdiff(m, MAG1) > TOL1) begin n_fail++; $display("FAIL mag_180 got %h want %h", m, MAG1); end
        // (0,-1): quadrant 3, angle 270
        run_one(32'h0, -32'sh10000, lat, a, p, m, r);
        n_checks += 2;
        if (angerr(a, 64'h10E0000) > ATOL) begin n_fail++; $display("FAIL ang_270 got %h want 10e0000", a); end
        if (p[17:16] !== 2'd3) begin n_fail++; $display("FAIL quad_270 got %0d want 3", p[17:16]); end
        // (0,0): everything zero
        run_one(32'h0, 32'h0, lat, a, p, m, r);
        n_checks += 3;
        if (a !== 32'h0) begin n_fail++; $display("FAIL ang_zero got %h want 0", a); end
        if (p !== 32'h0) begin n_fail++; $display("FAIL phase_zero got %h want 0", p); end
        if (m !== 32'h0) begin n_fail++; $display("FAIL mag_zero got %h want 0", m); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] xs [360];
        logic [31:0] ys [360];
        real rad;
        for (int d = 0; d < 360; d++) begin
            rad = real'(d) * 3.14159265358979 / 180.0;
            xs[d] = $rtoi(65536.0 * $cos(rad));
            ys[d] = $rtoi(65536.0 * $sin(rad));
        end
        @(negedge clk);
        fork
            begin
                for (int d = 0; d < 360; d++) begin
                    in_valid = 1'b1;
                    x_in = xs[d];
                    y_in = ys[d];
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (LAT) @(negedge clk);
                for (int d = 0; d < 360; d++) begin
                    n_checks += 2;
                    if (out_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sweep_valid deg %0d got %b want 1", d, out_valid);
                    end
                    if (angerr(angle, longint'(d) * 65536) > ATOL) begin
                        n_fail++;
                        $display("FAIL sweep_angle deg %0d got %h want %h", d, angle, d * 65536);
                    end
                    @(negedge clk);
                end
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_tail got %b want 0", out_valid);
                end
            end
        join
        repeat (LAT + 4) @(negedge clk);
    endtask

    task automatic test_gaps;
        logic [31:0] gx [12];
        logic [31:0] gy [12];
        logic        gv [12];
        longint      ge [12];
        longint      last;
        last = 0;
        for (int k = 0; k < 12; k++) begin
            gv[k] = (k % 2 == 0);
            if (!gv[k]) begin
                gx[k] = 32'h0;
                gy[k] = -32'sh10000;
                ge[k] = last;
            end else if (k % 4 == 0) begin
                gx[k] = 32'h10000;
                gy[k] = 32'h10000;
                ge[k] = 64'h2D0000;
            end else begin
                gx[k] = -32'sh10000;
                gy[k] = 32'h0;
                ge[k] = 64'hB40000;
            end
            last = ge[k];
        end
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    in_valid = gv[k];
                    x_in = gx[k];
                    y_in = gy[k];
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (LAT) @(negedge clk);
                for (int k = 0; k < 12; k++) begin
                    n_checks += 2;
                    if (out_valid !== gv[k]) begin
                        n_fail++;
                        $display("FAIL gap_valid slot %0d got %b want %b", k, out_valid, gv[k]);
                    end
                    if (angerr(angle, ge[k]) > ATOL) begin
                        n_fail++;
                        $display("FAIL gap_angle slot %0d got %h want %h", k, angle, ge[k]);
                    end
                    @(negedge clk);
                end
            end
        join
        repeat (LAT + 4) @(negedge clk);
    endtask

    task automatic test_reset_midstream;
        int seen;
        int lat;
        logic [31:0] a, p, m, r;
        @(negedge clk);
        for (int k = 0; k < LAT + 4; k++) begin
            in_valid = 1'b1;
            x_in = 32'h10000;
            y_in = 32'h10000;
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b want 1", out_valid); end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        if (angle !== 32'h0) begin n_fail++; $display("FAIL mid_rst_angle got %h want 0", angle); end
        if (phase_out !== 32'h0) begin n_fail++; $display("FAIL mid_rst_phase got %h want 0", phase_out); end
        if (magnitude !== 32'h0) begin n_fail++; $display("FAIL mid_rst_mag got %h want 0", magnitude); end
        if (residual !== 32'h0) begin n_fail++; $display("FAIL mid_rst_res got %h want 0", residual); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < LAT + 5; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL post_rst_leak got %0d valid cycles want 0", seen); end
        run_one(-32'sh10000, 32'h0, lat, a, p, m, r);
        n_checks += 3;
        if (lat != LAT) begin n_fail++; $display("FAIL post_rst_latency got %0d want %0d", lat, LAT); end
        if (angerr(a, 64'hB40000) > ATOL) begin n_fail++; $display("FAIL post_rst_angle got %h want b40000", a); end
        if (p !== 32'h1005A) begin n_fail++; $display("FAIL post_rst_phase got %h want 1005a", p); end
    endtask

    initial begin
        test_reset;
        test_unit_vectors;
        test_back_to_back;
        test_gaps;
        test_reset_midstream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
